// File: rtl/axil_csr_arbiter_pkg.sv
// Shared types and constants for the AXI4-Lite CSR arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axil_arb_pkg;

    // Sequencer states; one AXI4-Lite transaction is in flight at a time.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_AW_W = 3'd1,
        ST_WR_B    = 3'd2,
        ST_RD_AR   = 3'd3,
        ST_RD_R    = 3'd4,
        ST_ACK     = 3'd5
    } axil_arb_state_e;

    // AXI response codes; the arbiter forwards these, it never creates them.
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_csr_arbiter_rr_arbiter.sv
// Round-robin pick: first set request at or above the pointer, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides when the pick is consumed.
module rr_arbiter #(
    parameter int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    localparam logic [IDX_W:0] N_W = (IDX_W+1)'(N_REQ);

    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [IDX_W-1:0]   w_off;
    logic [IDX_W:0]     w_sum;

    // Rotate so the pointer position lands at bit 0; the doubled vector gives the wrap for free.
    assign w_dbl = {i_req, i_req};
    assign w_rot = w_dbl[i_ptr +: N_REQ];

    // Lowest set bit of the rotated vector is the distance from the pointer to the winner.
    always_comb begin
        w_off = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
            end
        end
    end

    assign w_sum   = {1'b0, i_ptr} + {1'b0, w_off};
    assign o_idx   = (w_sum >= N_W) ? IDX_W'(w_sum - N_W) : w_sum[IDX_W-1:0];
    assign o_any   = |i_req;
    assign o_grant = o_any ? (N_REQ'(1) << o_idx) : '0;

endmodule

// File: rtl/axil_csr_arbiter.sv
// Shares one AXI4-Lite CSR slave between N_REQ hold-until-ack requesters, round-robin.
// Latency: grant on the sampling edge, then AW/W (or AR), B (or R), and a one-cycle ack.
// Backpressure: each AXI channel waits on its ready/valid; requesters wait on req_ack.
module axil_csr_arbiter
    import axil_arb_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int STRB_W    = DATA_WIDTH / 8,
    localparam int IDX_W     = $clog2(N_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0]              req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_wdata,
    input  logic [N_REQ*STRB_W-1:0]       req_wstrb,
    output logic [N_REQ-1:0]              req_ack,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic [ADDR_WIDTH-1:0]         m_awaddr,
    output logic                          m_awvalid,
    input  logic                          m_awready,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    output logic [STRB_W-1:0]             m_wstrb,
    output logic                          m_wvalid,
    input  logic                          m_wready,
    input  logic [1:0]                    m_bresp,
    input  logic                          m_bvalid,
    output logic                          m_bready,
    output logic [ADDR_WIDTH-1:0]         m_araddr,
    output logic                          m_arvalid,
    input  logic                          m_arready,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    input  logic [1:0]                    m_rresp,
    input  logic                          m_rvalid,
    output logic                          m_rready
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    axil_arb_state_e       r_state;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_idx;
    logic [N_REQ-1:0]      r_grant;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_W-1:0]     r_wstrb;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic [N_REQ-1:0]      r_ack;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_resp;

    logic [N_REQ-1:0]      w_grant;
    logic [IDX_W-1:0]      w_idx;
    logic                  w_any;
    logic                  w_aw_done;
    logic                  w_w_done;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // A write address/data phase counts as done once its valid has been accepted,
    // either on an earlier edge (valid already dropped) or on this one.
    assign w_aw_done = ~r_awvalid | m_awready;
    assign w_w_done  = ~r_wvalid  | m_wready;

    // Transaction sequencer: grant, run one AXI4-Lite transfer, pulse the ack, advance the pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_grant   <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_ack     <= '0;
            r_rdata   <= '0;
            r_resp    <= RESP_OKAY;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_idx   <= w_idx;
                        r_grant <= w_grant;
                        r_addr  <= req_addr[w_idx*ADDR_WIDTH +: ADDR_WIDTH];
                        r_wdata <= req_wdata[w_idx*DATA_WIDTH +: DATA_WIDTH];
                        r_wstrb <= req_wstrb[w_idx*STRB_W +: STRB_W];
                        if (req_we[w_idx]) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR_AW_W;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_AR;
                        end
                    end
                end
                ST_WR_AW_W: begin
                    if (r_awvalid && m_awready) begin
                        r_awvalid <= 1'b0;
                    end
                    if (r_wvalid && m_wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (m_bvalid) begin
                        r_resp   <= m_bresp;
                        r_rdata  <= '0;
                        r_bready <= 1'b0;
                        r_ack    <= r_grant;
                        r_state  <= ST_ACK;
                    end
                end
                ST_RD_AR: begin
                    if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_R;
                    end
                end
                ST_RD_R: begin
                    if (m_rvalid) begin
                        r_rdata  <= m_rdata;
                        r_resp   <= m_rresp;
                        r_rready <= 1'b0;
                        r_ack    <= r_grant;
                        r_state  <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    // Requester drops req_valid on this edge; the next pick starts after it.
                    r_ptr   <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ack   = r_ack;
    assign rsp_rdata = r_rdata;
    assign rsp_resp  = r_resp;
    assign m_awaddr  = r_addr;
    assign m_awvalid = r_awvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = r_wstrb;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = r_bready;
    assign m_araddr  = r_addr;
    assign m_arvalid = r_arvalid;
    assign m_rready  = r_rready;

endmodule

// File: tb/tb_axil_csr_arbiter.sv
// Self-checking bench for axil_csr_arbiter with an AXI4-Lite memory slave model.
// Expected responses come from a transaction-level model pushed into a scoreboard.
// A monitor pops and compares on every req_ack.
module tb_axil_csr_arbiter;
    import axil_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_we;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N*SW-1:0]   req_wstrb;
    logic [N-1:0]      req_ack;
    logic [DW-1:0]     rsp_rdata;
    logic [1:0]        rsp_resp;
    logic [AW-1:0]     m_awaddr;
    logic              m_awvalid;
    logic              m_awready;
    logic [DW-1:0]     m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic              m_wvalid;
    logic              m_wready;
    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;
    logic [AW-1:0]     m_araddr;
    logic              m_arvalid;
    logic              m_arready;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rvalid;
    logic              m_rready;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    axil_csr_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_ack(req_ack), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    // ---------------- reference model and scoreboard ----------------
    logic [31:0] ref_mem   [0:255];
    logic [31:0] slave_mem [0:255];
    int          model_ptr;
    int          exp_id_q[$];
    logic [31:0] exp_rdata_q[$];
    logic [1:0]  exp_resp_q[$];
    logic        op_we    [N];
    logic [31:0] op_addr  [N];
    logic [31:0] op_wdata [N];
    logic [3:0]  op_wstrb [N];
    int          ack_seen = 0;

    // Slave behaviour knobs
    int stall_mode = 0;   // 0 zero-wait, 1 random, 2 W lags AW, 3 AW lags W
    int b_lat = 0;
    int r_lat = 0;

    function automatic logic addr_ok(input logic [31:0] a);
        return a < 32'h400;
    endfunction

    task automatic model_op(input int id, output logic [31:0] rd, output logic [1:0] rs);
        int w;
        w = int'(op_addr[id][9:2]);
        if (!addr_ok(op_addr[id])) begin
            rd = 32'h0;
            rs = RESP_SLVERR;
        end else if (op_we[id]) begin
            for (int b = 0; b < 4; b++)
                if (op_wstrb[id][b]) ref_mem[w][8*b +: 8] = op_wdata[id][8*b +: 8];
            rd = 32'h0;
            rs = RESP_OKAY;
        end else begin
            rd = ref_mem[w];
            rs = RESP_OKAY;
        end
    endtask

    task automatic set_op(input int id, input logic we, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        op_we[id] = we; op_addr[id] = a; op_wdata[id] = d; op_wstrb[id] = s;
    endtask

    task automatic rand_op(input int id);
        int r;
        r = $urandom_range(0, 7);
        op_we[id] = 1'($urandom_range(0, 1));
        if (r == 0)
            op_addr[id] = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC
                                                     : 32'h400 + 32'(4 * $urandom_range(0, 15));
        else
            op_addr[id] = 32'(4 * $urandom_range(0, 15));
        op_wdata[id] = $urandom;
        op_wstrb[id] = 4'($urandom_range(0, 15));
    endtask

    task automatic drive_fields(input int id);
        req_we[id]                = op_we[id];
        req_addr[id*AW +: AW]     = op_addr[id];
        req_wdata[id*DW +: DW]    = op_wdata[id];
        req_wstrb[id*SW +: SW]    = op_wstrb[id];
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic recover();
        apply_reset();
        exp_id_q.delete(); exp_rdata_q.delete(); exp_resp_q.delete();
        model_ptr = 0;
    endtask

    // Requesters in mask all raise together while the arbiter is idle; the grant
    // order is then every set requester in circular order starting at the pointer.
    task automatic run_round(input logic [N-1:0] mask);
        logic [31:0]  rd;
        logic [1:0]   rs;
        logic [N-1:0] pending;
        int id, last, cyc;
        last = model_ptr;
        for (int k = 0; k < N; k++) begin
            id = (model_ptr + k) % N;
            if (mask[id]) begin
                model_op(id, rd, rs);
                exp_id_q.push_back(id);
                exp_rdata_q.push_back(rd);
                exp_resp_q.push_back(rs);
                drive_fields(id);
                last = id;
            end
        end
        model_ptr = (last + 1) % N;
        req_valid = req_valid | mask;
        pending = mask;
        cyc = 0;
        while (pending != '0 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            pending   = pending & ~req_ack;
            req_valid = req_valid & ~req_ack;
        end
        if (pending != '0) begin
            vectors++; fails++;
            $display("FAIL round_timeout pending=%b required=00", pending);
            recover();
        end
    endtask

    // Monitor: every ack must match the oldest expected response.
    initial begin
        forever begin
            @(negedge clk);
            if (req_ack != '0) begin
                ack_seen++;
                vectors++;
                if (exp_id_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_ack ack=%b rdata=%h resp=%b required=no_ack",
                             req_ack, rsp_rdata, rsp_resp);
                end else begin
                    int          eid;
                    logic [31:0] erd;
                    logic [1:0]  ers;
                    logic [N-1:0] eack;
                    eid = exp_id_q.pop_front();
                    erd = exp_rdata_q.pop_front();
                    ers = exp_resp_q.pop_front();
                    eack = N'(1) << eid;
                    if (req_ack !== eack || rsp_rdata !== erd || rsp_resp !== ers) begin
                        fails++;
                        $display("FAIL ack_rsp got ack=%b rdata=%h resp=%b required ack=%b rdata=%h resp=%b",
                                 req_ack, rsp_rdata, rsp_resp, eack, erd, ers);
                    end
                end
            end
        end
    end

    // ---------------- AXI4-Lite slave model ----------------
    logic        s_have_aw, s_have_w, s_bpend, s_rpend;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    int          s_bcnt, s_rcnt, s_lag;

    initial begin
        logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic [31:0] c_aw, c_w, c_ar;
        logic [3:0]  c_s;
        int wi;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
        s_have_aw = 0; s_have_w = 0; s_bpend = 0; s_rpend = 0;
        s_awaddr = 0; s_wdata = 0; s_araddr = 0; s_wstrb = 0;
        s_bcnt = 0; s_rcnt = 0; s_lag = 0;
        forever begin
            @(negedge clk);
            aw_hs = m_awvalid && m_awready; c_aw = m_awaddr;
            w_hs  = m_wvalid  && m_wready;  c_w  = m_wdata; c_s = m_wstrb;
            b_hs  = m_bvalid  && m_bready;
            ar_hs = m_arvalid && m_arready; c_ar = m_araddr;
            r_hs  = m_rvalid  && m_rready;
            @(posedge clk); #1;
            if (!rst_n) begin
                s_have_aw = 0; s_have_w = 0; s_bpend = 0; s_rpend = 0; s_lag = 0;
                m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0;
                continue;
            end
            if (aw_hs) begin
                vectors++;
                if (s_have_aw) begin fails++; $display("FAIL dup_aw addr=%h required=single_aw", c_aw); end
                s_have_aw = 1; s_awaddr = c_aw;
            end
            if (w_hs) begin
                vectors++;
                if (s_have_w) begin fails++; $display("FAIL dup_w data=%h required=single_w", c_w); end
                s_have_w = 1; s_wdata = c_w; s_wstrb = c_s;
            end
            if (b_hs) begin
                s_bpend = 0; s_have_aw = 0; s_have_w = 0; m_bvalid = 0;
            end
            if (s_have_aw && s_have_w && !s_bpend) begin
                if (addr_ok(s_awaddr)) begin
                    wi = int'(s_awaddr[9:2]);
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) slave_mem[wi][8*b +: 8] = s_wdata[8*b +: 8];
                    m_bresp = RESP_OKAY;
                end else begin
                    m_bresp = RESP_SLVERR;
                end
                s_bpend = 1; s_bcnt = b_lat;
            end
            m_bvalid = s_bpend && (s_bcnt == 0);
            if (s_bpend && s_bcnt > 0) s_bcnt--;
            if (r_hs) begin
                s_rpend = 0; m_rvalid = 0;
            end
            if (ar_hs) begin
                vectors++;
                if (s_rpend) begin fails++; $display("FAIL dup_ar addr=%h required=single_ar", c_ar); end
                s_rpend = 1; s_rcnt = r_lat;
                if (addr_ok(c_ar)) begin
                    m_rdata = slave_mem[int'(c_ar[9:2])]; m_rresp = RESP_OKAY;
                end else begin
                    m_rdata = 32'h0; m_rresp = RESP_SLVERR;
                end
            end
            m_rvalid = s_rpend && (s_rcnt == 0);
            if (s_rpend && s_rcnt > 0) s_rcnt--;
            if ((stall_mode == 2 && s_have_aw && !s_have_w) ||
                (stall_mode == 3 && s_have_w && !s_have_aw)) s_lag++;
            else s_lag = 0;
            case (stall_mode)
                1: begin
                    m_awready = ($urandom_range(0, 2) != 0);
                    m_wready  = ($urandom_range(0, 2) != 0);
                    m_arready = ($urandom_range(0, 2) != 0);
                end
                2: begin m_awready = 1; m_wready = s_have_aw && (s_lag >= 3); m_arready = 1; end
                3: begin m_wready = 1; m_awready = s_have_w && (s_lag >= 3); m_arready = 1; end
                default: begin m_awready = 1; m_wready = 1; m_arready = 1; end
            endcase
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int start_acks, cyc;
        for (int i = 0; i < 256; i++) begin ref_mem[i] = 32'h0; slave_mem[i] = 32'h0; end
        model_ptr = 0;
        rst_n = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        #1;
        vectors++;
        if ({req_ack, rsp_rdata, rsp_resp, m_awvalid, m_wvalid, m_bready, m_arvalid,
             m_rready, m_awaddr, m_wdata, m_wstrb} !== '0) begin
            fails++;
            $display("FAIL reset_outputs ack=%b valids=%b%b%b%b%b required=all_zero",
                     req_ack, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Both at once from pointer 0: write then read of the same word.
        set_op(0, 1, 32'h0, 32'hDEAD_BEEF, 4'hF);
        set_op(1, 0, 32'h0, 32'h0, 4'h0);
        run_round(2'b11);

        // Byte-strobed write then readback.
        set_op(0, 1, 32'h20, 32'h1234_5678, 4'h1);
        run_round(2'b01);
        set_op(0, 0, 32'h20, 32'h0, 4'h0);
        run_round(2'b01);

        // Out-of-range read returns SLVERR; then both request and req0 must win.
        set_op(1, 0, 32'hFFFF_FFFC, 32'h0, 4'h0);
        run_round(2'b10);
        set_op(0, 0, 32'h20, 32'h0, 4'h0);
        set_op(1, 0, 32'h0, 32'h0, 4'h0);
        run_round(2'b11);

        // W lagging AW by three cycles, then AW lagging W.
        for (int m = 2; m <= 3; m++) begin
            stall_mode = m;
            set_op(1, 1, 32'h40 + 32'(m * 4), 32'hA5A5_0000 + 32'(m), 4'hF);
            run_round(2'b10);
            set_op(0, 0, 32'h40 + 32'(m * 4), 32'h0, 4'h0);
            run_round(2'b01);
        end
        stall_mode = 0;

        // Reset during WR_B: completed req0 moves pointer to 1, req1 is aborted.
        set_op(0, 1, 32'h80, 32'h0BAD_F00D, 4'hF);
        run_round(2'b01);
        begin
            logic [31:0] rd;
            logic [1:0]  rs;
            b_lat = 20;
            set_op(1, 1, 32'h84, 32'h7777_1111, 4'hF);
            model_op(1, rd, rs);   // AW and W reach the slave before reset
            drive_fields(1);
            req_valid = 2'b10;
            cyc = 0;
            while (!m_bready && cyc < 60) begin @(posedge clk); #1; cyc++; end
            vectors++;
            if (!m_bready) begin
                fails++;
                $display("FAIL reach_wr_b bready=%b required=1", m_bready);
            end
            #2;
            start_acks = ack_seen;
            rst_n = 1'b0;
            #1;
            vectors++;
            if ({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, req_ack} !== '0) begin
                fails++;
                $display("FAIL async_reset_drop valids=%b%b%b%b%b ack=%b required=all_zero",
                         m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, req_ack);
            end
            req_valid = '0;
            b_lat = 0;
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            vectors++;
            if (ack_seen != start_acks) begin
                fails++;
                $display("FAIL no_ack_after_reset acks=%0d required=%0d", ack_seen, start_acks);
            end
            model_ptr = 0;
        end
        set_op(0, 0, 32'h84, 32'h0, 4'h0);
        set_op(1, 0, 32'h80, 32'h0, 4'h0);
        run_round(2'b11);

        // Both continuously active: grants alternate.
        for (int r = 0; r < 4; r++) begin
            rand_op(0); rand_op(1);
            run_round(2'b11);
        end

        // Randomized traffic with random slave timing.
        for (int r = 0; r < 80; r++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, 3));
            stall_mode = ($urandom_range(0, 1) == 1) ? 1 : 0;
            b_lat = $urandom_range(0, 3);
            r_lat = $urandom_range(0, 3);
            rand_op(0); rand_op(1);
            run_round(mask);
        end

        repeat (5) @(posedge clk);
        #1;
        vectors++;
        if (exp_id_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_id_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog time=%0t required=finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
